// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the LSU decode queue and its lane decoders.
package lsu_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } lsu_size_e;

   typedef struct packed {
      logic       is_load;
      logic       zero_ext;
      lsu_size_e  size;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [11:0] imm;
      logic [1:0] lane;
   } lsu_uop_t;

   // Loads: LB, LH, LW, LBU, LHU.
   function automatic logic load_f3_legal(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   // Stores: SB, SH, SW.
   function automatic logic store_f3_legal(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
   endfunction

endpackage

// File: rtl/lsu_lane_decode.sv
// Combinational decode of one memory-slot instruction into a load/store micro-op.
module lsu_lane_decode
   import lsu_pkg::*;
#(
   parameter int LANE_IDX = 0
) (
   input  logic [31:0] inst,
   output logic        valid_op,
   output logic        is_nop,
   output logic        illegal,
   output lsu_uop_t    uop
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;
   logic       w_is_load;
   logic       w_is_store;

   assign w_opc      = inst[6:0];
   assign w_f3       = inst[14:12];
   assign is_nop     = (inst == 32'd0);
   assign w_is_load  = (w_opc == OPC_LOAD)  && load_f3_legal(w_f3);
   assign w_is_store = (w_opc == OPC_STORE) && store_f3_legal(w_f3);
   assign valid_op   = w_is_load || w_is_store;
   assign illegal    = !is_nop && !valid_op;

   always_comb begin
      uop = '0;
      if (valid_op) begin
         uop.is_load  = w_is_load;
         uop.zero_ext = w_is_load && w_f3[2];
         uop.size     = lsu_size_e'(w_f3[1:0]);
         uop.rs1      = inst[19:15];
         uop.rs2      = w_is_store ? inst[24:20] : 5'd0;
         uop.rd       = w_is_load ? inst[11:7] : 5'd0;
         uop.imm      = w_is_load ? inst[31:20] : {inst[31:25], inst[11:7]};
         uop.lane     = 2'(LANE_IDX);
      end
   end

endmodule

// File: rtl/lsu_decode_queue.sv
// Multi-lane load/store decoder with a compacting FIFO toward the LSU execute stage.
// Optional performance counters are enabled with LSU_DECODE_QUEUE_PERF_EN.
module lsu_decode_queue
   import lsu_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int DEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_LANES*32-1:0]      in_inst,
   output logic                         out_valid,
   input  logic                         out_ready,
   output lsu_uop_t                     out_uop,
   output logic                         illegal,
   output logic [NUM_LANES-1:0]         illegal_lanes,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef LSU_DECODE_QUEUE_PERF_EN
   ,
   output logic [15:0]                  perf_loads,
   output logic [15:0]                  perf_stores,
   output logic [15:0]                  perf_illegal
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   lsu_uop_t             r_mem [DEPTH];
   lsu_uop_t             r_last_uop;
   logic                 r_illegal;
   logic [NUM_LANES-1:0] r_illegal_lanes;

   logic [NUM_LANES-1:0] w_valid_op;
   logic [NUM_LANES-1:0] w_is_nop;
   logic [NUM_LANES-1:0] w_lane_illegal;
   logic [NUM_LANES-1:0] w_ill_mask;
   lsu_uop_t             w_uop [NUM_LANES];
   logic [PW-1:0]        w_slot [NUM_LANES];
   logic [CW-1:0]        w_push_cnt;
   logic                 w_push;
   logic                 w_pop;
   lsu_uop_t             w_head;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lsu_lane_decode #(.LANE_IDX(g)) u_dec (
         .inst     (in_inst[g*32 +: 32]),
         .valid_op (w_valid_op[g]),
         .is_nop   (w_is_nop[g]),
         .illegal  (w_lane_illegal[g]),
         .uop      (w_uop[g])
      );
   end

   assign w_ill_mask = w_lane_illegal & ~w_is_nop;

   // Handshake: a transfer happens on a cycle where valid && ready are both high at the
   // clock edge; flush forces both in_ready and out_valid low so nothing transfers.
   assign in_ready  = !flush && ((DEPTH - int'(r_count)) >= NUM_LANES);
   assign out_valid = !flush && (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Each legal lane lands at wr_ptr plus the number of legal lanes below it.
   always_comb begin
      w_push_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_slot[i] = PW'((int'(r_wr_ptr) + int'(w_push_cnt)) % DEPTH);
         if (w_valid_op[i]) w_push_cnt = w_push_cnt + CW'(1);
      end
   end

   assign w_head  = r_mem[r_rd_ptr];
   assign out_uop = (r_count != '0) ? w_head : r_last_uop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (w_valid_op[i]) r_mem[w_slot[i]] <= w_uop[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         r_last_uop      <= '0;
         r_illegal       <= 1'b0;
         r_illegal_lanes <= '0;
      end else begin
         r_illegal       <= w_push && (|w_ill_mask);
         r_illegal_lanes <= w_push ? w_ill_mask : '0;
         r_last_uop      <= out_uop;
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= PW'((int'(r_wr_ptr) + int'(w_push_cnt)) % DEPTH);
            if (w_pop)  r_rd_ptr <= PW'((int'(r_rd_ptr) + 1) % DEPTH);
            r_count <= r_count + (w_push ? w_push_cnt : CW'(0)) - (w_pop ? CW'(1) : CW'(0));
         end
      end
   end

   assign illegal       = r_illegal;
   assign illegal_lanes = r_illegal_lanes;
   assign count         = r_count;

`ifdef LSU_DECODE_QUEUE_PERF_EN
   logic [15:0] r_perf_loads;
   logic [15:0] r_perf_stores;
   logic [15:0] r_perf_illegal;
   logic [CW-1:0] w_n_loads;
   logic [CW-1:0] w_n_stores;
   logic [CW-1:0] w_n_illegal;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] n);
      logic [16:0] s;
      s = {1'b0, a} + 17'(n);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_comb begin
      w_n_loads   = '0;
      w_n_stores  = '0;
      w_n_illegal = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (w_valid_op[i] && w_uop[i].is_load)  w_n_loads   = w_n_loads + CW'(1);
         if (w_valid_op[i] && !w_uop[i].is_load) w_n_stores  = w_n_stores + CW'(1);
         if (w_ill_mask[i])                      w_n_illegal = w_n_illegal + CW'(1);
      end
   end

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_loads   <= '0;
         r_perf_stores  <= '0;
         r_perf_illegal <= '0;
      end else if (w_push) begin
         r_perf_loads   <= sat_add(r_perf_loads, w_n_loads);
         r_perf_stores  <= sat_add(r_perf_stores, w_n_stores);
         r_perf_illegal <= sat_add(r_perf_illegal, w_n_illegal);
      end
   end

   assign perf_loads   = r_perf_loads;
   assign perf_stores  = r_perf_stores;
   assign perf_illegal = r_perf_illegal;
`endif

endmodule
